pc_sequencer: RTL and testbench

Multi-cycle program-counter sequencer for the datapath. It fetches each instruction through a request/acknowledge handshake with instruction memory and waits for the decode/ALU stage to present the resolved control: Branch, Zero, Jump and immediates. It then computes and registers the next PC. The branch-taken decision (Branch AND Zero) is evaluated here as the consuming end of the branch-condition logic.

---
 rtl/pc_seq_pkg.sv | 15 +
 rtl/pc_sequencer_next_pc.sv | 44 ++++
 rtl/pc_sequencer.sv | 89 ++++++++
 tb/tb_pc_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2
  } state_t;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam int unsigned IMM_W_DEF    = 16;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned PC_INCR      = 4;

endpackage

// File: rtl/pc_sequencer_next_pc.sv
// Combinational next-PC selection: jump, taken branch, or sequential fall-through.
module next_pc
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IMM_W  = IMM_W_DEF
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  input  logic [IMM_W-1:0]  branch_imm,
  input  logic [ADDR_W-7:0] jump_target,
  output logic [ADDR_W-1:0] npc,
  output logic              taken
);

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] imm_ext;

  assign pc_plus4 = pc + ADDR_W'(PC_INCR);

  // Wide immediates are simply truncated; the sum wraps at ADDR_W anyway.
  generate
    if (IMM_W >= ADDR_W) begin : g_trunc
      assign imm_ext = branch_imm[ADDR_W-1:0];
    end else begin : g_sext
      assign imm_ext = {{(ADDR_W-IMM_W){branch_imm[IMM_W-1]}}, branch_imm};
    end
  endgenerate

  always_comb begin
    npc   = pc_plus4;
    taken = 1'b0;
    if (jump) begin
      npc   = {pc_plus4[ADDR_W-1:ADDR_W-4], jump_target, 2'b00};
      taken = 1'b1;
    end else if (branch && zero) begin
      npc   = pc_plus4 + (imm_ext << 2);
      taken = 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: fetch handshake, wait for resolved control, register next PC.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                IMM_W    = IMM_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ack,
  input  logic              dec_valid,
  input  logic              stall,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  input  logic [IMM_W-1:0]  branch_imm,
  input  logic [ADDR_W-7:0] jump_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              taken,
  output logic [31:0]       retire_count
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic              taken_reg;
  logic [31:0]       retire_reg;
  logic              load;
  logic [ADDR_W-1:0] npc;
  logic              npc_taken;

  next_pc #(
    .ADDR_W (ADDR_W),
    .IMM_W  (IMM_W)
  ) u_next_pc (
    .pc          (pc_reg),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .branch_imm  (branch_imm),
    .jump_target (jump_target),
    .npc         (npc),
    .taken       (npc_taken)
  );

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE:   state_next = FETCH;
      FETCH:  if (fetch_ack) state_next = DECODE;
      DECODE: begin
        if (dec_valid && !stall) begin
          load       = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Taken is only ever set on the loading edge, so it lasts one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      pc_reg     <= RESET_PC;
      taken_reg  <= 1'b0;
      retire_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      taken_reg <= load ? npc_taken : 1'b0;
      if (load) begin
        pc_reg     <= npc;
        retire_reg <= retire_reg + 32'd1;
      end
    end
  end

  assign fetch_req    = (state_reg == FETCH);
  assign fetch_addr   = pc_reg;
  assign pc           = pc_reg;
  assign pc_plus4     = pc_reg + ADDR_W'(PC_INCR);
  assign taken        = taken_reg;
  assign retire_count = retire_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: 32-bit instance plus an 8-bit wrap instance sharing stimulus.
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        m_rst_n, s_rst_n;
  logic        fetch_ack, dec_valid, stall, branch, zero, jump;
  logic [15:0] branch_imm;
  logic [25:0] jump_target;

  logic        m_req, m_tk, s_req, s_tk;
  logic [31:0] m_addr, m_pc, m_pc4, m_ret, s_ret;
  logic [7:0]  s_addr, s_pc, s_pc4;

  logic        sel_small;
  logic [31:0] o_pc, o_addr, o_ret;
  logic        o_req, o_tk;

  pc_sequencer #(
    .ADDR_W   (32),
    .IMM_W    (16),
    .RESET_PC (32'h0040_0000)
  ) u_main (
    .clk          (clk),
    .rst_n        (m_rst_n),
    .fetch_req    (m_req),
    .fetch_addr   (m_addr),
    .fetch_ack    (fetch_ack),
    .dec_valid    (dec_valid),
    .stall        (stall),
    .branch       (branch),
    .zero         (zero),
    .jump         (jump),
    .branch_imm   (branch_imm),
    .jump_target  (jump_target),
    .pc           (m_pc),
    .pc_plus4     (m_pc4),
    .taken        (m_tk),
    .retire_count (m_ret)
  );

  pc_sequencer #(
    .ADDR_W   (8),
    .IMM_W    (16),
    .RESET_PC (8'hFC)
  ) u_small (
    .clk          (clk),
    .rst_n        (s_rst_n),
    .fetch_req    (s_req),
    .fetch_addr   (s_addr),
    .fetch_ack    (fetch_ack),
    .dec_valid    (dec_valid),
    .stall        (stall),
    .branch       (branch),
    .zero         (zero),
    .jump         (jump),
    .branch_imm   (branch_imm),
    .jump_target  (jump_target[1:0]),
    .pc           (s_pc),
    .pc_plus4     (s_pc4),
    .taken        (s_tk),
    .retire_count (s_ret)
  );

  assign o_pc   = sel_small ? {24'h0, s_pc}   : m_pc;
  assign o_addr = sel_small ? {24'h0, s_addr} : m_addr;
  assign o_ret  = sel_small ? s_ret : m_ret;
  assign o_req  = sel_small ? s_req : m_req;
  assign o_tk   = sel_small ? s_tk  : m_tk;

  typedef struct packed {
    logic [31:0] pc;
    logic        tk;
    logic [31:0] ret;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   exp_ret = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge in FETCH, ends at the negedge after the loading edge (next FETCH).
  task automatic run_instr(input int ack_dly, input int stall_n,
                           input logic br, input logic z, input logic j,
                           input logic [15:0] imm, input logic [25:0] jt,
                           input logic [31:0] exp_pc, input logic exp_tk,
                           input string tag);
    logic [31:0] a0;
    exp_t        e;
    exp_ret++;
    sb_q.push_back('{pc: exp_pc, tk: exp_tk, ret: 32'(exp_ret)});
    chk({tag, ".req"}, 32'(o_req), 32'd1);
    a0 = o_addr;
    for (int i = 0; i < ack_dly; i++) begin
      @(negedge clk);
      chk({tag, ".hold_addr"}, o_addr, a0);
      chk({tag, ".tk_clear"}, 32'(o_tk), 32'd0);
    end
    fetch_ack = 1'b1;
    @(negedge clk);
    chk({tag, ".dec_req"}, 32'(o_req), 32'd0);
    // A lingering ack in DECODE must be ignored.
    fetch_ack   = (stall_n > 0);
    branch      = br;
    zero        = z;
    jump        = j;
    branch_imm  = imm;
    jump_target = jt;
    if (stall_n > 0) begin
      dec_valid = 1'b0;
      stall     = 1'b1;
      @(negedge clk);
      chk({tag, ".nodv_pc"}, o_pc, a0);
    end
    dec_valid = 1'b1;
    for (int i = 0; i < stall_n; i++) begin
      stall = 1'b1;
      @(negedge clk);
      chk({tag, ".stall_pc"}, o_pc, a0);
      chk({tag, ".stall_ret"}, o_ret, 32'(exp_ret - 1));
    end
    stall     = 1'b0;
    fetch_ack = 1'b0;
    @(negedge clk);
    dec_valid = 1'b0;
    branch = 1'b0; zero = 1'b0; jump = 1'b0;
    e = sb_q.pop_front();
    chk({tag, ".pc"}, o_pc, e.pc);
    chk({tag, ".addr"}, o_addr, e.pc);
    chk({tag, ".tk"}, 32'(o_tk), 32'(e.tk));
    chk({tag, ".ret"}, o_ret, e.ret);
  endtask

  initial begin
    sel_small = 1'b0;
    m_rst_n = 1'b0; s_rst_n = 1'b0;
    fetch_ack = 1'b0; dec_valid = 1'b0; stall = 1'b0;
    branch = 1'b0; zero = 1'b0; jump = 1'b0;
    branch_imm = '0; jump_target = '0;

    repeat (2) @(negedge clk);
    chk("rst.req", 32'(m_req), 32'd0);
    chk("rst.pc", m_pc, 32'h0040_0000);
    chk("rst.addr", m_addr, 32'h0040_0000);
    chk("rst.pc4", m_pc4, 32'h0040_0004);
    chk("rst.tk", 32'(m_tk), 32'd0);
    chk("rst.ret", m_ret, 32'd0);

    @(posedge clk); #1 m_rst_n = 1'b1;
    @(negedge clk);
    chk("start.req0", 32'(m_req), 32'd0);
    @(negedge clk);
    chk("start.req1", 32'(m_req), 32'd1);
    chk("start.addr", m_addr, 32'h0040_0000);

    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0,       32'h0040_0004, 1'b0, "fall");
    chk("fall.pc4", m_pc4, 32'h0040_0008);
    run_instr(0, 0, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h40,      32'h0000_0100, 1'b1, "jmp");
    run_instr(0, 0, 1'b1, 1'b1, 1'b0, 16'hFFFE, 26'h0,       32'h0000_00FC, 1'b1, "br_back");
    run_instr(3, 0, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h40,      32'h0000_0100, 1'b1, "late_ack");
    run_instr(0, 4, 1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0,       32'h0000_0104, 1'b0, "br_nt_stall");
    run_instr(0, 0, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h100004,  32'h0040_0010, 1'b1, "jmp_far");
    run_instr(1, 0, 1'b1, 1'b1, 1'b1, 16'h0005, 26'h0100000, 32'h0040_0000, 1'b1, "jmp_over_br");

    // 8-bit instance: wrap-around and asynchronous reset.
    m_rst_n   = 1'b0;
    sel_small = 1'b1;
    @(negedge clk);
    chk("s_rst.pc", 32'(s_pc), 32'h0000_00FC);
    chk("s_rst.pc4", 32'(s_pc4), 32'h0000_0000);
    @(posedge clk); #1 s_rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_ret = 0;
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0000_0000, 1'b0, "s_wrap");
    run_instr(0, 0, 1'b1, 1'b1, 1'b0, 16'hFFFE, 26'h0, 32'h0000_00FC, 1'b1, "s_br_wrap");
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0000_0000, 1'b0, "s_wrap2");

    fetch_ack = 1'b1;
    @(negedge clk);
    fetch_ack = 1'b0;
    chk("s_dec.pc", 32'(s_pc), 32'h0000_0000);
    #2 s_rst_n = 1'b0;
    #1;
    chk("s_async.pc", 32'(s_pc), 32'h0000_00FC);
    chk("s_async.ret", s_ret, 32'd0);
    chk("s_async.req", 32'(s_req), 32'd0);
    #1 s_rst_n = 1'b1;
    @(negedge clk);
    chk("s_restart.req", 32'(s_req), 32'd1);
    chk("s_restart.addr", 32'(s_addr), 32'h0000_00FC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
